// File: rtl/contador_regressivo_mmss_pkg.sv
// rtl/contador_regressivo_mmss_pkg.sv - shared types and constants for the MM:SS countdown timer
package contador_regressivo_mmss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } estado_t;

    localparam logic [3:0] BCD_MAX_UNIDADE = 4'd9;
    localparam logic [3:0] BCD_MAX_DEZENA  = 4'd5;

    // Digit positions inside the 16-bit MM:SS vector, shared with the up-counter display path.
    localparam int SU_LSB = 0;
    localparam int ST_LSB = 4;
    localparam int MU_LSB = 8;
    localparam int MT_LSB = 12;

    function automatic logic bcd_valido(input logic [15:0] v);
        return (v[SU_LSB +: 4] <= BCD_MAX_UNIDADE) &&
               (v[ST_LSB +: 4] <= BCD_MAX_DEZENA)  &&
               (v[MU_LSB +: 4] <= BCD_MAX_UNIDADE) &&
               (v[MT_LSB +: 4] <= BCD_MAX_DEZENA);
    endfunction

endpackage

// File: rtl/contador_regressivo_mmss_digito_regressivo.sv
// rtl/contador_regressivo_mmss_digito_regressivo.sv - one BCD down-counting digit with borrow out
module digito_regressivo
    import contador_regressivo_mmss_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX_UNIDADE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] d_in,
    input  logic       dec_en,
    output logic [3:0] q,
    output logic       borrow
);

    assign borrow = dec_en && (q == 4'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= 4'd0;
        end else if (load) begin
            q <= d_in;
        end else if (dec_en) begin
            q <= (q == 4'd0) ? MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/contador_regressivo_mmss.sv
// rtl/contador_regressivo_mmss.sv - MM:SS BCD countdown timer with prescaler, FSM and load validation
module contador_regressivo_mmss
    import contador_regressivo_mmss_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        carregar,
    input  logic [15:0] valor_in,
    input  logic        iniciar,
    input  logic        pausar,
    output logic [15:0] vetor,
    output logic        ativo,
    output logic        fim,
    output logic        erro
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

    estado_t       estado, estado_next;
    logic [PW-1:0] prescaler, prescaler_next;
    logic          ativo_next, fim_next, erro_next;

    logic          valido, carregar_aceito, load_ok;
    logic          tick, zero, um, underflow;
    logic          load_digitos;
    logic [15:0]   d_digitos;
    logic [3:0]    su, st, mu, mt;
    logic          b_su, b_st, b_mu;

    assign valido          = bcd_valido(valor_in);
    assign carregar_aceito = carregar && (estado != RUN);
    assign load_ok         = carregar_aceito && valido;
    assign zero            = (vetor == 16'h0000);
    assign um              = (vetor == 16'h0001);
    assign tick            = (estado == RUN) && !pausar && (prescaler == TICK_MAX);

    // A borrow out of the minutes tens would mean counting below 00:00; clamp instead of wrapping.
    assign load_digitos = load_ok || underflow;
    assign d_digitos    = underflow ? 16'h0000 : valor_in;

    digito_regressivo #(.MAX(BCD_MAX_UNIDADE)) u_su (
        .clock(clock), .reset(reset), .load(load_digitos), .d_in(d_digitos[SU_LSB +: 4]),
        .dec_en(tick), .q(su), .borrow(b_su)
    );
    digito_regressivo #(.MAX(BCD_MAX_DEZENA)) u_st (
        .clock(clock), .reset(reset), .load(load_digitos), .d_in(d_digitos[ST_LSB +: 4]),
        .dec_en(b_su), .q(st), .borrow(b_st)
    );
    digito_regressivo #(.MAX(BCD_MAX_UNIDADE)) u_mu (
        .clock(clock), .reset(reset), .load(load_digitos), .d_in(d_digitos[MU_LSB +: 4]),
        .dec_en(b_st), .q(mu), .borrow(b_mu)
    );
    digito_regressivo #(.MAX(BCD_MAX_DEZENA)) u_mt (
        .clock(clock), .reset(reset), .load(load_digitos), .d_in(d_digitos[MT_LSB +: 4]),
        .dec_en(b_mu), .q(mt), .borrow(underflow)
    );

    assign vetor[SU_LSB +: 4] = su;
    assign vetor[ST_LSB +: 4] = st;
    assign vetor[MU_LSB +: 4] = mu;
    assign vetor[MT_LSB +: 4] = mt;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= IDLE;
            prescaler <= '0;
            ativo     <= 1'b0;
            fim       <= 1'b0;
            erro      <= 1'b0;
        end else begin
            estado    <= estado_next;
            prescaler <= prescaler_next;
            ativo     <= ativo_next;
            fim       <= fim_next;
            erro      <= erro_next;
        end
    end

    always_comb begin
        estado_next = estado;
        case (estado)
            IDLE: begin
                if (!carregar_aceito && iniciar) begin
                    estado_next = zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (pausar) begin
                    estado_next = PAUSE;
                end else if (tick && um) begin
                    estado_next = DONE;
                end
            end
            PAUSE: begin
                if (load_ok) begin
                    estado_next = IDLE;
                end else if (!carregar_aceito && !pausar && iniciar) begin
                    estado_next = RUN;
                end
            end
            DONE: begin
                if (load_ok) begin
                    estado_next = IDLE;
                end
            end
            default: estado_next = IDLE;
        endcase
    end

    always_comb begin
        prescaler_next = prescaler;
        fim_next       = 1'b0;
        erro_next      = erro;
        ativo_next     = (estado_next == RUN);
        if (load_ok) begin
            prescaler_next = '0;
            erro_next      = 1'b0;
        end else if (carregar_aceito) begin
            erro_next = 1'b1;
        end else begin
            case (estado)
                IDLE: begin
                    if (iniciar) begin
                        prescaler_next = '0;
                        fim_next       = zero;
                    end
                end
                RUN: begin
                    // Pause freezes the prescaler, which also swallows a tick due on this edge.
                    if (!pausar) begin
                        prescaler_next = tick ? '0 : prescaler + PW'(1);
                        fim_next       = tick && um;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_contador_regressivo_mmss.sv
// tb/tb_contador_regressivo_mmss.sv - scoreboard bench for the MM:SS countdown timer
module tb_contador_regressivo_mmss;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        carregar = 1'b0;
    logic [15:0] valor_in = 16'h0000;
    logic        iniciar = 1'b0;
    logic        pausar = 1'b0;
    logic [15:0] vetor;
    logic        ativo, fim, erro;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        string       nome;
        logic [15:0] vetor;
        logic        ativo;
        logic        fim;
        logic        erro;
    } esperado_t;

    esperado_t sb[$];
    esperado_t mx;

    contador_regressivo_mmss #(.TICK_DIV(4)) dut (
        .clock(clock), .reset(reset), .carregar(carregar), .valor_in(valor_in),
        .iniciar(iniciar), .pausar(pausar), .vetor(vetor), .ativo(ativo),
        .fim(fim), .erro(erro)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mx = sb.pop_front();
            checks++;
            if (mx.cyc != cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d reached only at cycle %0d", mx.nome, mx.cyc, cyc);
            end else if (vetor !== mx.vetor || ativo !== mx.ativo || fim !== mx.fim || erro !== mx.erro) begin
                failures++;
                $display("FAIL %s: got vetor=%h ativo=%b fim=%b erro=%b, expected vetor=%h ativo=%b fim=%b erro=%b",
                         mx.nome, vetor, ativo, fim, erro, mx.vetor, mx.ativo, mx.fim, mx.erro);
            end
        end
    end

    task automatic espera(input int k, input string nome, input logic [15:0] v,
                          input logic a, input logic f, input logic e);
        esperado_t x;
        x.cyc = cyc + k;
        x.nome = nome;
        x.vetor = v;
        x.ativo = a;
        x.fim = f;
        x.erro = e;
        sb.push_back(x);
    endtask

    task automatic passo(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        passo(3);
        reset = 1'b0;
        espera(0, "reset_state", 16'h0000, 0, 0, 0);
        passo(1);

        // Full borrow 01:00 -> 00:59, invalid load before start leaves erro set through RUN
        carregar = 1'b1; valor_in = 16'h0100;
        passo(1); espera(0, "load_0100", 16'h0100, 0, 0, 0);
        valor_in = 16'h0A00;
        passo(1); espera(0, "load_bad_0A00_idle", 16'h0100, 0, 0, 1);
        carregar = 1'b0; iniciar = 1'b1;
        passo(1); espera(0, "start_0100", 16'h0100, 1, 0, 1);
        iniciar = 1'b0; carregar = 1'b1; valor_in = 16'h1234;
        passo(1); espera(0, "run_load_ignored", 16'h0100, 1, 0, 1);
        carregar = 1'b0;
        espera(2, "before_first_tick", 16'h0100, 1, 0, 1);
        espera(3, "tick_0059", 16'h0059, 1, 0, 1);
        passo(3);
        reset = 1'b1;
        passo(1); espera(0, "reset_midrun", 16'h0000, 0, 0, 0);
        reset = 1'b0;

        // 00:02 down to 00:00, single fim pulse, DONE ignores iniciar
        carregar = 1'b1; valor_in = 16'h0002;
        passo(1); espera(0, "load_0002", 16'h0002, 0, 0, 0);
        carregar = 1'b0; iniciar = 1'b1;
        passo(1); espera(0, "start_0002", 16'h0002, 1, 0, 0);
        iniciar = 1'b0;
        espera(4, "tick_0001", 16'h0001, 1, 0, 0);
        espera(7, "hold_0001", 16'h0001, 1, 0, 0);
        espera(8, "reach_zero_fim", 16'h0000, 0, 1, 0);
        espera(9, "fim_one_cycle", 16'h0000, 0, 0, 0);
        passo(9);
        iniciar = 1'b1;
        espera(1, "done_ignores_start_1", 16'h0000, 0, 0, 0);
        espera(3, "done_ignores_start_3", 16'h0000, 0, 0, 0);
        passo(3);
        iniciar = 1'b0;

        // Invalid loads from DONE, then a valid one clears erro
        carregar = 1'b1; valor_in = 16'h0A00;
        passo(1); espera(0, "load_bad_0A00", 16'h0000, 0, 0, 1);
        valor_in = 16'h6000;
        passo(1); espera(0, "load_bad_6000", 16'h0000, 0, 0, 1);
        valor_in = 16'h5959;
        passo(1); espera(0, "load_5959", 16'h5959, 0, 0, 0);
        valor_in = 16'h0010; iniciar = 1'b1;
        passo(1); espera(0, "load_beats_start", 16'h0010, 0, 0, 0);
        carregar = 1'b0; iniciar = 1'b0;
        passo(1); espera(0, "still_idle", 16'h0010, 0, 0, 0);

        // Pause/resume keeps the sub-second phase; pause on a tick edge suppresses it
        iniciar = 1'b1;
        passo(1); espera(0, "start_0010", 16'h0010, 1, 0, 0);
        iniciar = 1'b0;
        passo(2);
        pausar = 1'b1;
        passo(1); espera(0, "pause_enter", 16'h0010, 0, 0, 0);
        espera(9, "pause_hold", 16'h0010, 0, 0, 0);
        passo(9);
        pausar = 1'b0; iniciar = 1'b1;
        passo(1); espera(0, "resume", 16'h0010, 1, 0, 0);
        iniciar = 1'b0;
        espera(1, "resume_plus1", 16'h0010, 1, 0, 0);
        espera(2, "resume_tick_0009", 16'h0009, 1, 0, 0);
        passo(5);
        pausar = 1'b1;
        passo(1); espera(0, "pause_on_tick", 16'h0009, 0, 0, 0);
        iniciar = 1'b1;
        passo(1); espera(0, "pause_beats_start", 16'h0009, 0, 0, 0);
        pausar = 1'b0;
        passo(1); espera(0, "resume_at_phase3", 16'h0009, 1, 0, 0);
        iniciar = 1'b0;
        espera(1, "tick_0008", 16'h0008, 1, 0, 0);
        passo(1);
        reset = 1'b1;
        passo(1); espera(0, "reset_again", 16'h0000, 0, 0, 0);
        reset = 1'b0;

        // Start at 00:00 from IDLE goes straight to DONE; iniciar beats pausar in IDLE
        iniciar = 1'b1; pausar = 1'b1;
        passo(1); espera(0, "zero_start_fim", 16'h0000, 0, 1, 0);
        iniciar = 1'b0; pausar = 1'b0;
        passo(1); espera(0, "zero_start_after", 16'h0000, 0, 0, 0);

        passo(3);
        if (sb.size() != 0) begin
            failures += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations never checked, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
